pipe_skid_reg32: RTL and testbench
==================================

PIPE_SKID_REG32 -- requirements
Module: pipe_skid_reg32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream consumes out_data this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: downstream payload, driven from the main register.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held words (present only under PIPE_SKID_FLUSH_EN).

Function
REQ-011 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-012 The block SHALL hold a main register and a skid register, with state EMPTY, ONE or FULL.
REQ-013 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-014 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-015 In EMPTY, in_fire SHALL load main <= in_data and move to ONE.
REQ-016 In ONE with in_fire and no out_fire, the block SHALL load skid <= in_data and move to FULL.
REQ-017 In ONE with out_fire and no in_fire, the block SHALL move to EMPTY; main keeps its stale value.
REQ-018 In ONE with in_fire and out_fire together, the block SHALL load main <= in_data and stay in ONE.
REQ-019 In FULL with out_fire, the block SHALL load main <= skid and move to ONE; without out_fire it SHALL hold all registers.
REQ-020 Latency from in_fire to out_valid with that word SHALL be exactly 1 cycle when EMPTY.
REQ-021 Sustained throughput SHALL be 1 word per cycle while out_ready stays 1.
REQ-022 Words SHALL leave in acceptance order, with none lost or duplicated.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL force next state EMPTY, overriding all transitions; a word offered during flush is dropped even if in_fire=1.

Reset
REQ-025 rst=0 SHALL immediately, without waiting for a clock edge, force state EMPTY, main=0 and skid=0, giving in_ready=1, out_valid=0 and out_data=0.
REQ-026 Reset mid-transfer SHALL discard held words; after release the block SHALL behave as from power-up on the first rising edge.

Configuration
REQ-027 With PIPE_SKID_FLUSH_EN defined, the block SHALL include the flush port and REQ-024.
REQ-028 Without PIPE_SKID_FLUSH_EN, the block SHALL omit the flush port and all its logic; behaviour SHALL otherwise be identical.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the WIDTH default constant.
REQ-030 The block SHALL use no sub-module; the state FSM and the two data registers are inline.

Verification
REQ-031 Reset, then in_valid=1 with in_data=0x11111111 and out_ready=1 -> out_valid=1 and out_data=0x11111111 next cycle; in_ready stays 1.
REQ-032 out_ready=0, push 0xA and then 0xB -> state FULL and in_ready=0; raise out_ready -> 0xA then 0xB on consecutive cycles.
REQ-033 Stream 0x1..0x8 with out_ready=1 on every cycle -> 8 outputs in 8 consecutive cycles, in order, with in_ready never 0.
REQ-034 In FULL (0xA, 0xB), assert flush for 1 cycle while offering 0xC -> out_valid=0 next cycle and 0xC never appears.
REQ-035 Assert rst=0 asynchronously mid-cycle while in ONE holding 0x55 -> out_valid=0 and out_data=0 before the next clock edge.
REQ-036 Random in_valid/out_ready over 10k cycles against a scoreboard -> no loss, duplication or reorder, and out_data stable whenever stalled.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipe_skid_reg32 skid buffer.
//   - WIDTH_DEFAULT : default payload width in bits
//   - state_e       : occupancy state encoding (EMPTY / ONE / FULL)
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Number of words held: EMPTY = none, ONE = main only, FULL = main + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_reg32.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg32
//   Two-entry skid buffer: a main register that drives out_data directly and
//   a skid register that catches the word accepted in the cycle the
//   downstream stalls. in_ready is decoded from registered state only, so
//   there is no combinational path from out_ready to in_ready.
//
//   Optional feature: define PIPE_SKID_FLUSH_EN to add the flush port, which
//   empties the buffer and drops any word offered in the same cycle.
//
//   Handshake: a word moves on a channel in a cycle where valid and ready
//   are both 1 at the rising clock edge; valid must not depend on ready, and
//   a producer holding valid=1 keeps its data stable until the transfer.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  block can accept a word this cycle
//   in_data    in   upstream payload [WIDTH-1:0]
//   out_valid  out  out_data holds a valid word
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  downstream payload [WIDTH-1:0], from the main register
//   flush      in   discard all held words (PIPE_SKID_FLUSH_EN only)
//   dbg_state  out  current occupancy state, for observation only
// -----------------------------------------------------------------------------
module pipe_skid_reg32
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign out_data  = main_q;
    assign dbg_state = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    // main keeps its stale value; out_valid masks it.
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is 0 here, so only the drain side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush wins over every transition; the data registers are left
        // untouched because an EMPTY state makes their contents invisible.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg32.sv
module tb_pipe_skid_reg32;
  import pipe_pkg::*;

  localparam int W = 32;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   dbg_state;
`ifdef PIPE_SKID_FLUSH_EN
  logic         flush;
`endif

  always #5 clk = ~clk;

  pipe_skid_reg32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance across one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic         stalled;
    logic [W-1:0] held;
    logic         in_f;
    logic         out_f;
    int           budget;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
`ifdef PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    #2 rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_state", {30'b0, dbg_state}, 32'd0);
    step();
    step();
    rst = 1'b1;

    // Single word, 1-cycle latency.
    drive(1'b1, 32'h11111111, 1'b1);
    chk("t31_in_ready_pre", {31'b0, in_ready}, 32'd1);
    step();
    chk("t31_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t31_out_data", out_data, 32'h11111111);
    chk("t31_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b0, '0, 1'b1);
    step();
    chk("t31_drained", {31'b0, out_valid}, 32'd0);

    // Fill to FULL under stall, then drain in order.
    drive(1'b1, 32'hA, 1'b0);
    step();
    chk("t32_one_data", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0);
    step();
    chk("t32_full_state", {30'b0, dbg_state}, 32'd2);
    chk("t32_full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t32_full_out_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, '0, 1'b0);
    step();
    chk("t32_stall_data", out_data, 32'hA);
    out_ready = 1'b1;
    chk("t32_first_out", out_data, 32'hA);
    step();
    chk("t32_second_out", out_data, 32'hB);
    chk("t32_second_valid", {31'b0, out_valid}, 32'd1);
    chk("t32_ready_again", {31'b0, in_ready}, 32'd1);
    step();
    chk("t32_empty", {31'b0, out_valid}, 32'd0);

    // Back-to-back stream, one word per cycle.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      chk($sformatf("t33_in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
      step();
      chk($sformatf("t33_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("t33_data_%0d", i), out_data, W'(i));
    end
    drive(1'b0, '0, 1'b1);
    step();
    chk("t33_empty", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_SKID_FLUSH_EN
    // Flush while FULL, with a word offered in the same cycle.
    drive(1'b1, 32'hA, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0);
    step();
    chk("t34_full", {30'b0, dbg_state}, 32'd2);
    drive(1'b1, 32'hC, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("t34_valid_after_flush", {31'b0, out_valid}, 32'd0);
    chk("t34_ready_after_flush", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t34_no_c", {31'b0, out_valid}, 32'd0);
    end
    // Flush while ONE with a simultaneous accept also drops the offer.
    drive(1'b1, 32'hD, 1'b0);
    step();
    drive(1'b1, 32'hC, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("t34_one_flush", {31'b0, out_valid}, 32'd0);
`endif

    // Asynchronous reset in the middle of a cycle while holding a word.
    drive(1'b1, 32'h55, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("t35_holding", out_data, 32'h55);
    #2 rst = 1'b0;
    #1;
    chk("t35_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t35_async_data", out_data, 32'd0);
    chk("t35_async_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h77, 1'b1);
    step();
    chk("t35_post_valid", {31'b0, out_valid}, 32'd1);
    chk("t35_post_data", out_data, 32'h77);
    drive(1'b0, '0, 1'b1);
    step();
    chk("t35_post_empty", {31'b0, out_valid}, 32'd0);

    // Random soak against the expected queue.
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 50);
      if (stalled) begin
        chk("t36_stall_valid", {31'b0, out_valid}, 32'd1);
        chk("t36_stall_data", out_data, held);
      end
      in_f  = in_valid & in_ready;
      out_f = out_valid & out_ready;
      if (out_f) begin
        if (exp_q.size() == 0) begin
          chk("t36_spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("t36_order", out_data, exp_q.pop_front());
        end
      end
      if (in_f) exp_q.push_back(in_data);
      stalled = out_valid & ~out_ready;
      held    = out_data;
      step();
    end
    drive(1'b0, '0, 1'b1);
    budget = 0;
    while (out_valid && budget < 10) begin
      if (exp_q.size() != 0) chk("t36_drain", out_data, exp_q.pop_front());
      else chk("t36_drain_extra", {31'b0, out_valid}, 32'd0);
      step();
      budget++;
    end
    chk("t36_queue_empty", exp_q.size(), 32'd0);
    chk("t36_final_valid", {31'b0, out_valid}, 32'd0);

    // ---------------------------------------------------------------- report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
